dec_counter: RTL and testbench



---
 rtl/dec_counter.sv | 67 ++++++
 tb/tb_dec_counter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/dec_counter.sv
// Single-digit modulo-MODULUS up/down counter with clamped preload and wrap carry.
// Define DEC_COUNTER_CARRY_REG_EN to register o_carry so it aligns with the wrapped value.
module dec_counter #(
  parameter int MODULUS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_init,
  input  logic       i_init_vld,
  input  logic       i_enable,
  input  logic       i_count_down,
  output logic [3:0] o_value,
  output logic       o_carry
);

  localparam logic [3:0] MaxVal = 4'(MODULUS - 1);

  logic [3:0] value_q, value_d;
  logic       wrap;

  // A wrap is an enabled step that rolls over the digit boundary in the current direction.
  assign wrap = i_enable & ~i_init_vld & ~rst &
                (i_count_down ? (value_q == 4'd0) : (value_q == MaxVal));

  always_comb begin
    value_d = value_q;
    if (i_init_vld) begin
      value_d = (i_init > MaxVal) ? MaxVal : i_init;
    end else if (i_enable) begin
      if (i_count_down) begin
        value_d = (value_q == 4'd0) ? MaxVal : value_q - 4'd1;
      end else begin
        value_d = (value_q == MaxVal) ? 4'd0 : value_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign o_value = value_q;

`ifdef DEC_COUNTER_CARRY_REG_EN
  logic carry_q, carry_d;

  assign carry_d = wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

  assign o_carry = carry_q;
`else
  // Combinational carry lets the next digit step on the same edge as this digit wraps.
  assign o_carry = wrap;
`endif

endmodule

// File: tb/tb_dec_counter.sv
// Scoreboard bench for dec_counter: expectations are queued as each cycle's stimulus is driven.
// Honours DEC_COUNTER_CARRY_REG_EN to select the expected carry timing.
module tb_dec_counter;

  localparam int M = 10;

  typedef struct {
    string      tag;
    logic [3:0] value;
    logic       carry;
  } expect_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] i_init = 4'd0;
  logic       i_init_vld = 1'b0;
  logic       i_enable = 1'b0;
  logic       i_count_down = 1'b0;
  logic [3:0] o_value;
  logic       o_carry;

  int checkCount = 0;
  int errorCount = 0;
  int modelValue = 0;
  bit modelCarry = 1'b0;
  expect_t scoreboard[$];

  dec_counter #(.MODULUS(M)) dut (
    .clk(clk),
    .rst(rst),
    .i_init(i_init),
    .i_init_vld(i_init_vld),
    .i_enable(i_enable),
    .i_count_down(i_count_down),
    .o_value(o_value),
    .o_carry(o_carry)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Pure reference model: modular arithmetic, independent of the RTL structure.
  function automatic bit modelWrap(input bit r, input bit vld, input bit en, input bit dn);
    return en && !vld && !r && (dn ? (modelValue == 0) : (modelValue == M - 1));
  endfunction

  task automatic applyStimulus(input string tag, input bit r, input int init, input bit vld,
                               input bit en, input bit dn);
    expect_t e;
    bit      w;
    rst = r;
    i_init = 4'(init);
    i_init_vld = vld;
    i_enable = en;
    i_count_down = dn;
    w = modelWrap(r, vld, en, dn);
    e.tag = tag;
    e.value = 4'(modelValue);
`ifdef DEC_COUNTER_CARRY_REG_EN
    e.carry = modelCarry;
`else
    e.carry = w;
`endif
    scoreboard.push_back(e);
    @(negedge clk);
    e = scoreboard.pop_front();
    checkOutput({e.tag, " value"}, o_value, e.value);
    checkOutput({e.tag, " carry"}, {3'b000, o_carry}, {3'b000, e.carry});
    @(posedge clk);
    if (r) modelValue = 0;
    else if (vld) modelValue = (init > M - 1) ? M - 1 : init;
    else if (en) modelValue = dn ? (modelValue + M - 1) % M : (modelValue + 1) % M;
    modelCarry = w;
    #1;
  endtask

  initial begin
    // Establish a known state before anything is compared.
    @(posedge clk);
    #1;
    modelValue = 0;
    modelCarry = 1'b0;

    for (int i = 0; i < 3; i++) applyStimulus("reset", 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus("load3", 0, 3, 1, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus("countUp", 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus("gateOff", 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus("resume", 0, 0, 0, 1, 0);

    applyStimulus("load2", 0, 2, 1, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus("countDown", 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus("frozen", 0, 0, 0, 0, 1);

    applyStimulus("clamp12", 0, 12, 1, 1, 0);
    applyStimulus("afterClamp", 0, 0, 0, 1, 0);
    applyStimulus("clamp15", 0, 15, 1, 1, 1);
    applyStimulus("downFromMax", 0, 0, 0, 1, 1);

    // Direction flip with enable held at each boundary.
    applyStimulus("load0", 0, 0, 1, 0, 0);
    applyStimulus("flipAt0Up", 0, 0, 0, 0, 0);
    applyStimulus("flipAt0Down", 0, 0, 0, 1, 1);
    applyStimulus("flipAt9Up", 0, 0, 0, 1, 0);
    applyStimulus("postFlip", 0, 0, 0, 1, 0);

    applyStimulus("load6", 0, 6, 1, 0, 0);
    applyStimulus("midReset", 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus("restart", 0, 0, 0, 1, 0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus("random", ($urandom_range(0, 29) == 0), int'($urandom_range(0, 15)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
